// File: rtl/vga_frame_scheduler_if.sv
// rtl/vga_frame_scheduler_if.sv - display-update offer handshake between control logic and scheduler.
interface vga_frame_scheduler_if;
  logic       upd_valid;
  logic [7:0] upd_destination;
  logic [1:0] upd_sim_state;
  logic       upd_ready;

  modport master (
    output upd_valid,
    output upd_destination,
    output upd_sim_state,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_destination,
    input  upd_sim_state,
    output upd_ready
  );
endinterface

// File: rtl/vga_frame_scheduler.sv
// rtl/vga_frame_scheduler.sv - buffers one display update and commits it at vblank start; frame tick and blink.
module vga_frame_scheduler #(
  parameter int unsigned VERT_PIXEL   = 480,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned FCNT_W       = 5
) (
  input  logic                  pixel_clk,
  input  logic                  reset,
  input  logic [9:0]            horiz_count,
  input  logic [9:0]            vert_count,
  vga_frame_scheduler_if.slave  upd,
  output logic [7:0]            destination,
  output logic [1:0]            sim_state,
  output logic                  commit_pulse,
  output logic                  frame_tick,
  output logic                  blink
);

  typedef enum logic {S_IDLE, S_PENDING} state_e;

  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

  state_e            state_q, state_d;
  logic [7:0]        buf_dest_q, buf_dest_d;
  logic [1:0]        buf_state_q, buf_state_d;
  logic [7:0]        dest_q, dest_d;
  logic [1:0]        sim_q, sim_d;
  logic              commit_q, commit_d;
  logic              tick_q, tick_d;
  logic              blink_q, blink_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic vblank_start;
  logic accept;

  assign vblank_start  = (horiz_count == 10'd0) && (vert_count == 10'(VERT_PIXEL));
  assign upd.upd_ready = (state_q == S_IDLE);
  assign accept        = upd.upd_valid && (state_q == S_IDLE);

  always_comb begin
    state_d     = state_q;
    buf_dest_d  = buf_dest_q;
    buf_state_d = buf_state_q;
    dest_d      = dest_q;
    sim_d       = sim_q;
    commit_d    = 1'b0;
    tick_d      = vblank_start;
    fcnt_d      = fcnt_q;
    blink_d     = blink_q;

    if (state_q == S_IDLE) begin
      if (accept) begin
        if (vblank_start) begin
          // Offer landing exactly on vblank goes straight to the display.
          dest_d   = upd.upd_destination;
          sim_d    = upd.upd_sim_state;
          commit_d = 1'b1;
        end else begin
          buf_dest_d  = upd.upd_destination;
          buf_state_d = upd.upd_sim_state;
          state_d     = S_PENDING;
        end
      end
    end else begin
      if (vblank_start) begin
        dest_d   = buf_dest_q;
        sim_d    = buf_state_q;
        commit_d = 1'b1;
        state_d  = S_IDLE;
      end
    end

    if (vblank_start) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      buf_dest_q  <= 8'h00;
      buf_state_q <= 2'b00;
      dest_q      <= 8'h00;
      sim_q       <= 2'b00;
      commit_q    <= 1'b0;
      tick_q      <= 1'b0;
      blink_q     <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      buf_dest_q  <= buf_dest_d;
      buf_state_q <= buf_state_d;
      dest_q      <= dest_d;
      sim_q       <= sim_d;
      commit_q    <= commit_d;
      tick_q      <= tick_d;
      blink_q     <= blink_d;
      fcnt_q      <= fcnt_d;
    end
  end

  assign destination  = dest_q;
  assign sim_state    = sim_q;
  assign commit_pulse = commit_q;
  assign frame_tick   = tick_q;
  assign blink        = blink_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// tb/tb_vga_frame_scheduler.sv - directed self-checking bench for vga_frame_scheduler.
module tb_vga_frame_scheduler;
  logic       pixel_clk = 1'b0;
  logic       reset     = 1'b1;
  logic [9:0] horiz_count = 10'd5;
  logic [9:0] vert_count  = 10'd5;
  logic [7:0] destination;
  logic [1:0] sim_state;
  logic       commit_pulse;
  logic       frame_tick;
  logic       blink;

  int checks = 0;
  int errors = 0;

  vga_frame_scheduler_if upd_if ();

  vga_frame_scheduler #(
    .VERT_PIXEL  (480),
    .BLINK_FRAMES(3),
    .FCNT_W      (2)
  ) dut (
    .pixel_clk   (pixel_clk),
    .reset       (reset),
    .horiz_count (horiz_count),
    .vert_count  (vert_count),
    .upd         (upd_if),
    .destination (destination),
    .sim_state   (sim_state),
    .commit_pulse(commit_pulse),
    .frame_tick  (frame_tick),
    .blink       (blink)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic step(input int h, input int v);
    horiz_count = 10'(h);
    vert_count  = 10'(v);
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic [1:0] s,
                         input logic c, input logic t, input logic b, input logic r);
    chk({tag, ".dest"},   32'(destination),      32'(d));
    chk({tag, ".sim"},    32'(sim_state),        32'(s));
    chk({tag, ".commit"}, 32'(commit_pulse),     32'(c));
    chk({tag, ".tick"},   32'(frame_tick),       32'(t));
    chk({tag, ".blink"},  32'(blink),            32'(b));
    chk({tag, ".ready"},  32'(upd_if.upd_ready), 32'(r));
  endtask

  initial begin
    upd_if.upd_valid       = 1'b0;
    upd_if.upd_destination = 8'h00;
    upd_if.upd_sim_state   = 2'b00;

    step(5, 5);
    step(6, 5);
    reset = 1'b0;
    chk_out("reset", 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Two idle frames: one tick each, no commit.
    step(1, 100); chk_out("idle0_vis",  8'h00, 2'b00, 0, 0, 0, 1);
    step(0, 480); chk_out("idle0_vbl",  8'h00, 2'b00, 0, 1, 0, 1);
    step(1, 480); chk_out("idle0_post", 8'h00, 2'b00, 0, 0, 0, 1);
    step(0, 480); chk_out("idle1_vbl",  8'h00, 2'b00, 0, 1, 0, 1);
    step(1, 480); chk_out("idle1_post", 8'h00, 2'b00, 0, 0, 0, 1);

    // Buffered update 10/01 accepted mid-frame.
    upd_if.upd_valid = 1'b1; upd_if.upd_destination = 8'h10; upd_if.upd_sim_state = 2'b01;
    step(3, 100); chk_out("acc10", 8'h00, 2'b00, 0, 0, 0, 0);
    upd_if.upd_destination = 8'h20; upd_if.upd_sim_state = 2'b11;
    step(4, 100); chk_out("pend_hold", 8'h00, 2'b00, 0, 0, 0, 0);
    step(0, 480); chk_out("commit10", 8'h10, 2'b01, 1, 1, 1, 1);
    step(1, 480); chk_out("acc20", 8'h10, 2'b01, 0, 0, 1, 0);
    upd_if.upd_valid = 1'b0;
    step(2, 100); chk_out("vis10", 8'h10, 2'b01, 0, 0, 1, 0);
    step(0, 480); chk_out("commit20", 8'h20, 2'b11, 1, 1, 1, 1);
    step(1, 480); chk_out("post20", 8'h20, 2'b11, 0, 0, 1, 1);

    // Bypass: offer exactly on vblank_start from idle.
    upd_if.upd_valid = 1'b1; upd_if.upd_destination = 8'h04; upd_if.upd_sim_state = 2'b10;
    step(0, 480); chk_out("bypass", 8'h04, 2'b10, 1, 1, 1, 1);
    upd_if.upd_valid = 1'b0;
    step(1, 100); chk_out("post_bypass", 8'h04, 2'b10, 0, 0, 1, 1);

    // Reset while pending discards the buffered update.
    upd_if.upd_valid = 1'b1; upd_if.upd_destination = 8'hFF; upd_if.upd_sim_state = 2'b11;
    step(5, 100); chk_out("accFF", 8'h04, 2'b10, 0, 0, 1, 0);
    upd_if.upd_valid = 1'b0;
    reset = 1'b1;
    step(6, 100); chk_out("rst_pend", 8'h00, 2'b00, 0, 0, 0, 1);
    reset = 1'b0;
    step(0, 480); chk_out("no_commitFF", 8'h00, 2'b00, 0, 1, 0, 1);
    step(1, 480); chk_out("postFF", 8'h00, 2'b00, 0, 0, 0, 1);

    // Reset coinciding with vblank_start: no commit, no tick.
    upd_if.upd_valid = 1'b1; upd_if.upd_destination = 8'h33; upd_if.upd_sim_state = 2'b01;
    step(5, 100); chk_out("acc33", 8'h00, 2'b00, 0, 0, 0, 0);
    upd_if.upd_valid = 1'b0;
    reset = 1'b1;
    step(0, 480); chk_out("rst_vbl", 8'h00, 2'b00, 0, 0, 0, 1);
    reset = 1'b0;

    // Blink with BLINK_FRAMES=3: toggles after the 3rd and 6th vblank_start.
    for (int i = 1; i <= 7; i++) begin
      logic exp_blink;
      exp_blink = ((i / 3) % 2) == 1;
      step(0, 480); chk_out($sformatf("blink_vbl%0d", i), 8'h00, 2'b00, 0, 1, exp_blink, 1);
      step(1, 480); chk_out($sformatf("blink_post%0d", i), 8'h00, 2'b00, 0, 0, exp_blink, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
